instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Owns the program counter and the IF/ID pipeline register, sitting directly upstream of the program memory ROM. Drives the word-aligned byte address into the ROM each cycle, captures the returned instruction (combinational ROM read) together with PC+4 into the IF/ID register, and supports stall, flush and redirect (branch/jump) from later stages. Also keeps a fetch counter for bring-up and performance checks.

## Interface
- DATA_WIDTH, 32, width of PC, instruction and counter
- RESET_PC, 32'h0000_0000, PC value loaded on reset (byte address, must be word aligned)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active low (sampled on rising edge of clk)
- stall_i  input  1  hold PC and IF/ID contents
- flush_i  input  1  invalidate IF/ID (insert bubble)
- redirect_i  input  1  load PC from redirect_pc_i
- redirect_pc_i  input  DATA_WIDTH  branch/jump target byte address
- instruction_i  input  DATA_WIDTH  instruction word from ROM for address pc_o (same cycle)
- pc_o  output  DATA_WIDTH  current PC, drives ROM address input
- if_id_instruction_o  output  DATA_WIDTH  registered instruction
- if_id_pc_plus4_o  output  DATA_WIDTH  registered PC+4 of that instruction
- if_id_valid_o  output  1  IF/ID holds a real instruction
- fetch_count_o  output  DATA_WIDTH  number of valid instructions captured into IF/ID
- align_error_o  output  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Priority per edge: reset > redirect_i > stall_i > normal advance.
- Normal: pc_o <= pc_o + 4; IF/ID <= {instruction_i, pc_o + 4}, valid <= 1 unless flush_i.
- stall_i=1 (no redirect): pc_o, IF/ID and valid all hold; flush_i with stall_i still clears valid (instruction/pc fields hold).
- redirect_i=1: pc_o <= redirect_pc_i regardless of stall_i; IF/ID valid <= 0, instruction <= 32'h0000_0000 (sll nop), pc_plus4 <= 0; the word at the old pc_o is discarded.
- flush_i=1, redirect_i=0, stall_i=0: PC advances normally; IF/ID loaded with bubble (instruction 0, valid 0).
- Bubble encoding always 32'h0000_0000 with valid 0.
- PC arithmetic modulo 2^DATA_WIDTH: 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- fetch_count_o increments by 1 on every edge where valid is written as 1 (new capture, not hold); wraps modulo 2^DATA_WIDTH.
- Reset values: pc_o = RESET_PC, if_id_instruction_o = 0, if_id_pc_plus4_o = 0, if_id_valid_o = 0, fetch_count_o = 0, align_error_o = 0.

## Timing
- pc_o is a register; ROM output is valid the same cycle; IF/ID captures at the next rising edge: 1-cycle latency PC-to-IF/ID.
- First valid instruction (word at RESET_PC) appears on if_id_* at the first edge with reset=1, no stall/flush/redirect.
- Redirect takes effect on the sampling edge: next cycle pc_o = target; target instruction valid in IF/ID one edge later (one bubble cycle per redirect).
- Reset asserted mid-stream: all outputs return to reset values at that edge, overriding stall/redirect.
- All inputs sampled on rising edge only; no combinational path from inputs to outputs.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc_i[1:0] != 2'b00 sets align_error_o = 1 (sticky until reset) and pc_o loads target with bits [1:0] forced to 0.
- Not defined: align_error_o tied 0; redirect_pc_i loaded unmodified (ROM ignores bits [1:0]).

## Test plan
- Reset release, ROM word n = 32'h1000_0000+n, no stall: after 3 edges pc_o=12, if_id_instruction_o=32'h1000_0002, if_id_pc_plus4_o=12, valid=1, fetch_count_o=3.
- stall_i high 2 cycles at pc_o=8: pc_o stays 8, IF/ID unchanged, fetch_count_o unchanged; resumes at 12 after release.
- redirect_i with redirect_pc_i=32'h40 while stall_i=1: next cycle pc_o=0x40, valid=0, instruction=0; one edge later instruction=ROM[16], pc_plus4=0x44.
- flush_i alone at pc_o=4: pc_o=8, valid=0, instruction=0, fetch_count_o not incremented.
- Reset asserted during redirect: pc_o=RESET_PC, all IF/ID fields 0, count 0, align_error_o 0.
- With FETCH_ALIGN_CHECK_EN, redirect to 32'h22: pc_o=0x20, align_error_o=1 and stays 1 until reset; without macro pc_o=0x22, align_error_o=0.

Source files
------------

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: hazard controls in, ROM address/data and IF/ID register out.
// master = fetch stage side, slave = pipeline control / ROM / decode side.
interface instruction_fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  stall_i;
    logic                  flush_i;
    logic                  redirect_i;
    logic [DATA_WIDTH-1:0] redirect_pc_i;
    logic [DATA_WIDTH-1:0] instruction_i;
    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] if_id_instruction_o;
    logic [DATA_WIDTH-1:0] if_id_pc_plus4_o;
    logic                  if_id_valid_o;
    logic [DATA_WIDTH-1:0] fetch_count_o;
    logic                  align_error_o;

    modport master (
        input  stall_i, flush_i, redirect_i,
        input  redirect_pc_i, instruction_i,
        output pc_o, if_id_instruction_o,
        output if_id_pc_plus4_o, if_id_valid_o,
        output fetch_count_o, align_error_o
    );

    modport slave (
        output stall_i, flush_i, redirect_i,
        output redirect_pc_i, instruction_i,
        input  pc_o, if_id_instruction_o,
        input  if_id_pc_plus4_o, if_id_valid_o,
        input  fetch_count_o, align_error_o
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Program counter, IF/ID register and fetch counter.
// Define FETCH_ALIGN_CHECK_EN to flag and word-align misaligned redirects.
module instruction_fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input logic                        clk,
    input logic                        reset,
    instruction_fetch_stage_if.master  bus
);
    localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] pc4_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] target;

    assign pc_plus4 = pc_q + FOUR;

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_err_q;

    assign target = {bus.redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

    // Sticky flag for redirects to a non word-aligned target
    always_ff @(posedge clk) begin
        if (!reset)
            align_err_q <= 1'b0;
        else if (bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00))
            align_err_q <= 1'b1;
    end

    assign bus.align_error_o = align_err_q;
`else
    assign target            = bus.redirect_pc_i;
    assign bus.align_error_o = 1'b0;
`endif

    // PC and IF/ID update: reset > redirect > stall > advance
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else if (bus.redirect_i) begin
            pc_q    <= target;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.stall_i) begin
            if (bus.flush_i)
                valid_q <= 1'b0;
        end else begin
            pc_q <= pc_plus4;
            if (bus.flush_i) begin
                instr_q <= '0;
                pc4_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                instr_q <= bus.instruction_i;
                pc4_q   <= pc_plus4;
                valid_q <= 1'b1;
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign bus.pc_o                = pc_q;
    assign bus.if_id_instruction_o = instr_q;
    assign bus.if_id_pc_plus4_o    = pc4_q;
    assign bus.if_id_valid_o       = valid_q;
    assign bus.fetch_count_o       = count_q;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a ROM model
// returning 32'h1000_0000 + word index for every fetch address.
module tb_instruction_fetch_stage;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    instruction_fetch_stage_if #(.DATA_WIDTH(32)) bus ();

    instruction_fetch_stage #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    // Combinational ROM: word n holds 32'h1000_0000 + n
    assign bus.instruction_i = 32'h1000_0000 + {2'b00, bus.pc_o[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc,
                             input logic [31:0] ins, input logic [31:0] p4,
                             input logic v, input logic [31:0] cnt);
        chk({tag, ".pc"}, bus.pc_o, pc);
        chk({tag, ".instr"}, bus.if_id_instruction_o, ins);
        chk({tag, ".pc4"}, bus.if_id_pc_plus4_o, p4);
        chk({tag, ".valid"}, {31'd0, bus.if_id_valid_o}, {31'd0, v});
        chk({tag, ".count"}, bus.fetch_count_o, cnt);
    endtask

    initial begin
        n_cmp             = 0;
        n_err             = 0;
        reset             = 1'b0;
        bus.stall_i       = 1'b0;
        bus.flush_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;

        tick();
        chk_state("rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("rst.align", {31'd0, bus.align_error_o}, 32'd0);

        reset = 1'b1;
        tick(); tick(); tick();
        chk_state("run3", 32'd12, 32'h1000_0002, 32'd12, 1'b1, 32'd3);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick(); tick();
        chk_state("pre_stall", 32'd8, 32'h1000_0001, 32'd8, 1'b1, 32'd2);

        bus.stall_i = 1'b1;
        tick(); tick();
        chk_state("stall", 32'd8, 32'h1000_0001, 32'd8, 1'b1, 32'd2);

        bus.stall_i = 1'b0;
        tick();
        chk_state("resume", 32'd12, 32'h1000_0002, 32'd12, 1'b1, 32'd3);

        bus.stall_i = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        chk_state("stflush", 32'd12, 32'h1000_0002, 32'd12, 1'b0, 32'd3);

        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        tick();
        chk_state("after_sf", 32'd16, 32'h1000_0003, 32'd16, 1'b1, 32'd4);

        bus.stall_i       = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h40;
        tick();
        chk_state("redir", 32'h40, 32'h0, 32'h0, 1'b0, 32'd4);

        bus.stall_i    = 1'b0;
        bus.redirect_i = 1'b0;
        tick();
        chk_state("redir_tgt", 32'h44, 32'h1000_0010, 32'h44, 1'b1, 32'd5);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("fl_pre.pc", bus.pc_o, 32'd4);
        bus.flush_i = 1'b1;
        tick();
        chk("flush.pc", bus.pc_o, 32'd8);
        chk("flush.valid", {31'd0, bus.if_id_valid_o}, 32'd0);
        chk("flush.instr", bus.if_id_instruction_o, 32'h0);
        chk("flush.count", bus.fetch_count_o, 32'd1);
        bus.flush_i = 1'b0;

        bus.stall_i       = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h80;
        reset             = 1'b0;
        tick();
        chk_state("rst_redir", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        chk("rst_redir.align", {31'd0, bus.align_error_o}, 32'd0);

        reset             = 1'b1;
        bus.stall_i       = 1'b0;
        bus.redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        chk_state("wrap_pre", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd0);
        bus.redirect_i = 1'b0;
        tick();
        chk_state("wrap", 32'h0, 32'h4FFF_FFFF, 32'h0, 1'b1, 32'd1);

        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h22;
        tick();
        bus.redirect_i = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis.pc", bus.pc_o, 32'h20);
        chk("mis.align", {31'd0, bus.align_error_o}, 32'd1);
        tick();
        chk("mis.sticky", {31'd0, bus.align_error_o}, 32'd1);
        chk("mis.pc_next", bus.pc_o, 32'h24);
`else
        chk("mis.pc", bus.pc_o, 32'h22);
        chk("mis.align", {31'd0, bus.align_error_o}, 32'd0);
        tick();
        chk("mis.sticky", {31'd0, bus.align_error_o}, 32'd0);
        chk("mis.pc_next", bus.pc_o, 32'h26);
`endif
        reset = 1'b0;
        tick();
        chk("mis.rst", {31'd0, bus.align_error_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
